// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin one-hot arbiter.
//   arb_state_e : FSM encoding (IDLE -> GRANT -> RELEASE -> IDLE)
//   onehot()    : index -> one-hot vector, sized for the largest legal N;
//                 callers truncate to their own N.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int ARB_MAX_N = 16;
    localparam int ARB_IDX_W = 4;

    function automatic logic [ARB_MAX_N-1:0] onehot(input logic [ARB_IDX_W-1:0] idx);
        logic [ARB_MAX_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick.
//   i_req   : request vector
//   i_ptr   : search start index (highest priority)
//   o_win   : index of first set request at or after i_ptr, wrapping past N-1
//   o_found : high when any request is set
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_win,
    output logic          o_found
);

    // Walk offsets 0..N-1 from the pointer; the first hit wins. The
    // modulo keeps the wrap correct for non-power-of-two N.
    always_comb begin
        o_found = 1'b0;
        o_win   = '0;
        for (int i = 0; i < N; i++) begin
            if (!o_found && i_req[(int'(i_ptr) + i) % N]) begin
                o_found = 1'b1;
                o_win   = IW'((int'(i_ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter producing a zero-or-one-hot grant vector.
// A grant is held until done, or until the hold watchdog expires, and is
// always followed by one mandatory all-zero RELEASE cycle.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req[N]      : level-sensitive requests
//   done        : owner releases the grant (ignored unless granted)
//   gnt[N]      : registered zero-or-one-hot grant
//   gnt_valid   : |gnt
//   gnt_id      : index of granted requester, 0 when idle
//   timeout_err : one-cycle pulse on a watchdog-forced release
module rr_onehot_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 done,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 timeout_err
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(HOLD_MAX + 1);

    arb_state_e      r_state, w_state_nx;
    logic [IW-1:0]   r_ptr, w_ptr_nx;
    logic [CW-1:0]   r_hold, w_hold_nx;
    logic [N-1:0]    r_gnt, w_gnt_nx;
    logic [IW-1:0]   r_gnt_id, w_gnt_id_nx;
    logic            r_gnt_valid, w_gnt_valid_nx;
    logic            r_timeout, w_timeout_nx;

    logic [IW-1:0]   w_win;
    logic            w_found;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_win   (w_win),
        .o_found (w_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_hold      <= '0;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_ptr       <= w_ptr_nx;
            r_hold      <= w_hold_nx;
            r_gnt       <= w_gnt_nx;
            r_gnt_id    <= w_gnt_id_nx;
            r_gnt_valid <= w_gnt_valid_nx;
            r_timeout   <= w_timeout_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_ptr_nx       = r_ptr;
        w_hold_nx      = r_hold;
        w_gnt_nx       = r_gnt;
        w_gnt_id_nx    = r_gnt_id;
        w_gnt_valid_nx = r_gnt_valid;
        w_timeout_nx   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nx     = GRANT;
                    w_gnt_nx       = N'(onehot(ARB_IDX_W'(w_win)));
                    w_gnt_id_nx    = w_win;
                    w_gnt_valid_nx = 1'b1;
                    w_hold_nx      = CW'(1);
                end
            end
            GRANT: begin
                // done takes precedence over an expiring watchdog, so no
                // error pulse when both land on the same edge. req is not
                // looked at here: the owner keeps the grant regardless.
                if (done || (r_hold == CW'(HOLD_MAX))) begin
                    w_state_nx     = RELEASE;
                    w_gnt_nx       = '0;
                    w_gnt_id_nx    = '0;
                    w_gnt_valid_nx = 1'b0;
                    w_hold_nx      = '0;
                    w_ptr_nx       = (r_gnt_id == IW'(N - 1)) ? '0 : r_gnt_id + IW'(1);
                    w_timeout_nx   = !done;
                end else begin
                    // Only reached below HOLD_MAX, so the counter saturates.
                    w_hold_nx = r_hold + CW'(1);
                end
            end
            RELEASE: begin
                // Guaranteed gnt=0 cycle between owners.
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign gnt         = r_gnt;
    assign gnt_valid   = r_gnt_valid;
    assign gnt_id      = r_gnt_id;
    assign timeout_err = r_timeout;

endmodule
